pipe_mux_reg: RTL and testbench
===============================

// Module: pipe_mux_reg
//
// PURPOSE
//   Parametrised N-way, WIDTH-bit selector with a registered output stage, for pipeline operand and forwarding selection.
//   Replaces chains of 1-bit 2:1 muxes in front of stage registers (e.g. EX operand select).
//   Adds valid tracking, stall (hold), flush (bubble insert) and a sticky out-of-range-select error flag.
//   One cycle of latency from input sample to m_out.
//
// PARAMETERS
//   WIDTH        32            data width per input lane, >=1
//   N            2             number of input lanes, >=1
//   DEFAULT_VAL  {WIDTH{1'b0}} value loaded when sel >= N
//   SEL_W        derived       localparam = max(1, clog2(N)); not overridable
//
// PORTS
//   clk        in   1        rising-edge clock (single clock domain)
//   reset      in   1        synchronous, active-high reset
//   in_bus     in   N*WIDTH  flattened lanes; lane k = in_bus[k*WIDTH +: WIDTH]
//   sel        in   SEL_W    lane select
//   in_valid   in   1        current inputs carry a real instruction
//   stall      in   1        hold stage register contents
//   flush      in   1        insert bubble
//   m_out      out  WIDTH    registered selected lane
//   out_valid  out  1        m_out holds a real instruction
//   sel_err    out  1        sticky: a valid load used sel >= N
//
// BEHAVIOUR
//   - One clock, one reset. Reset is synchronous and active-high; all state updates on posedge clk only.
//   - Reset values: m_out=0, out_valid=0, sel_err=0. Reset wins over every other input, including in_valid.
//   - Per-edge priority: reset > flush > stall > load.
//   - flush: m_out<=0, out_valid<=0; sel_err unchanged; overrides stall in the same cycle.
//   - stall (no flush): m_out, out_valid and sel_err all hold; sel and in_bus ignored.
//   - load (no flush, no stall):
//       in_valid=1, sel<N:  m_out<=lane[sel], out_valid<=1.
//       in_valid=1, sel>=N: m_out<=DEFAULT_VAL, out_valid<=1, sel_err<=1.
//       in_valid=0:         out_valid<=0, m_out holds, sel_err unchanged.
//   - sel_err clears only on reset; set and no-change are the only other transitions.
//   - Out-of-range detection applies whenever 2**SEL_W > N (e.g. N=3, or N=1 with sel=1).
//   - Latency: data sampled at edge t appears on m_out after edge t; no combinational input->output path.
//   - Reset mid-stream (stall or flush active): outputs take reset values at that edge.
//     The first load is accepted on the first edge after reset deasserts.
//   - Selection logic is a width-generic indexed part-select; no per-lane hand instantiation.
//
// TESTING
//   1. reset=1 for 2 cycles with in_valid=1, sel=1, stall=1 -> m_out=0, out_valid=0, sel_err=0.
//   2. N=4, WIDTH=32, lanes {0x44,0x33,0x22,0x11}, in_valid=1, sweep sel 0..3
//      -> m_out=0x11,0x22,0x33,0x44 one cycle later; out_valid=1 throughout.
//   3. Load sel=2 (0x33), then stall=1 for 3 cycles while sel and lanes change
//      -> m_out=0x33 and out_valid=1 held; after release, the new lane appears one edge later.
//   4. flush=1 and stall=1 in the same cycle, with m_out=0x33 -> next edge m_out=0, out_valid=0, sel_err unchanged.
//   5. N=3, DEFAULT_VAL=0xDEADBEEF, in_valid=1, sel=3 -> m_out=0xDEADBEEF, out_valid=1, sel_err=1.
//      Then sel=0 -> m_out=lane0 with sel_err still 1; reset -> sel_err=0.
//   6. in_valid=0 after m_out=0x22 -> out_valid=0, m_out=0x22 held.
//      Same for sel=3 with N=3: sel_err stays 0.

Source files
------------

// File: rtl/pipe_mux_reg.sv
// N-way WIDTH-bit lane selector with a registered output stage.
// Carries valid, stall hold, flush bubble and a sticky bad-select flag.
module pipe_mux_reg #(
  parameter  int              WIDTH       = 32,
  parameter  int              N           = 2,
  parameter  logic [WIDTH-1:0] DEFAULT_VAL = {WIDTH{1'b0}},
  localparam int              SEL_W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  output logic [WIDTH-1:0]   m_out,
  output logic               out_valid,
  output logic               sel_err
);

  localparam logic [SEL_W:0] N_W = (SEL_W + 1)'(N);

  logic             in_range;
  logic [WIDTH-1:0] lane;

  // Extra zero bit keeps the compare exact when N == 2**SEL_W.
  assign in_range = {1'b0, sel} < N_W;

  always_comb begin
    lane = DEFAULT_VAL;
    if (in_range)
      lane = in_bus[int'(sel)*WIDTH +: WIDTH];
  end

  logic do_flush;
  logic do_hold;
  logic do_load;

  assign do_flush = flush;
  assign do_hold  = !flush && stall;
  assign do_load  = !flush && !stall && in_valid;

  logic [WIDTH-1:0] m_n;
  logic             v_n;
  logic             err_n;

  always_comb begin
    m_n   = m_out;
    v_n   = out_valid;
    err_n = sel_err;
    unique case (1'b1)
      do_flush: begin
        m_n = '0;
        v_n = 1'b0;
      end
      do_hold: begin
        m_n = m_out;
        v_n = out_valid;
      end
      do_load: begin
        m_n   = lane;
        v_n   = 1'b1;
        err_n = sel_err | !in_range;
      end
      default: begin
        v_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_out     <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      m_out     <= m_n;
      out_valid <= v_n;
      sel_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_pipe_mux_reg.sv
// Scoreboard bench for pipe_mux_reg: a 4-lane and a 3-lane
// instance share control inputs; each step pushes its expectation.
module tb_pipe_mux_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset    = 1'b1;
  logic         in_valid = 1'b0;
  logic         stall    = 1'b0;
  logic         flush    = 1'b0;
  logic [1:0]   sel      = '0;
  logic [127:0] bus4     = '0;
  logic [95:0]  bus3     = '0;

  logic [31:0] m4, m3;
  logic        v4, v3, e4, e3;

  pipe_mux_reg #(.WIDTH(32), .N(4)) u4 (
    .clk(clk), .reset(reset), .in_bus(bus4), .sel(sel),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .m_out(m4), .out_valid(v4), .sel_err(e4)
  );

  pipe_mux_reg #(.WIDTH(32), .N(3), .DEFAULT_VAL(32'hDEADBEEF)) u3 (
    .clk(clk), .reset(reset), .in_bus(bus3), .sel(sel),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .m_out(m3), .out_valid(v3), .sel_err(e3)
  );

  typedef struct {
    string       name;
    bit          d3;
    logic [31:0] m;
    logic        v;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  localparam logic [127:0] LANES4 = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] ALT4   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [95:0]  LANES3 = {32'h333, 32'h222, 32'h111};

  task automatic apply(input logic r, input logic f, input logic s,
                       input logic v, input logic [1:0] sl);
    @(negedge clk);
    reset = r; flush = f; stall = s; in_valid = v; sel = sl;
  endtask

  task automatic push(input string n, input bit d3, input logic [31:0] m,
                      input logic v, input logic e);
    exp_t x;
    x.name = n; x.d3 = d3; x.m = m; x.v = v; x.e = e;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0, 1'b1, 1'b1, 2'd1);
      bus4 = LANES4; bus3 = LANES3;
      push("reset_n4", 1'b0, 32'h0, 1'b0, 1'b0);
      push("reset_n3", 1'b1, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        exp_t x = sb.pop_front();
        logic [31:0] am = x.d3 ? m3 : m4;
        logic av = x.d3 ? v3 : v4;
        logic ae = x.d3 ? e3 : e4;
        checks++;
        if (am !== x.m || av !== x.v || ae !== x.e)
          $display("FAIL %s: got m_out=%h valid=%b err=%b want %h %b %b",
                   x.name, am, av, ae, x.m, x.v, x.e);
        else passed++;
      end
    end
  endtask

  task automatic test_sweep();
    bus4 = LANES4;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] want = 32'h11 * (i + 1);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 2'(i));
      push($sformatf("sweep_sel%0d", i), 1'b0, want, 1'b1, 1'b0);
      @(posedge clk); #1;
      begin
        exp_t x = sb.pop_front();
        checks++;
        if (m4 !== x.m || v4 !== x.v || e4 !== x.e)
          $display("FAIL %s: got m_out=%h valid=%b err=%b want %h %b %b",
                   x.name, m4, v4, e4, x.m, x.v, x.e);
        else passed++;
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        bus4 = LANES4;
        apply(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        push("stall_load", 1'b0, 32'h33, 1'b1, 1'b0);
      end else if (i < 4) begin
        bus4 = ALT4;
        apply(1'b0, 1'b0, 1'b1, 1'b1, 2'(i - 1));
        push($sformatf("stall_hold%0d", i), 1'b0, 32'h33, 1'b1, 1'b0);
      end else begin
        apply(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        push("stall_release", 1'b0, 32'hA0, 1'b1, 1'b0);
      end
      @(posedge clk); #1;
      begin
        exp_t x = sb.pop_front();
        checks++;
        if (m4 !== x.m || v4 !== x.v || e4 !== x.e)
          $display("FAIL %s: got m_out=%h valid=%b err=%b want %h %b %b",
                   x.name, m4, v4, e4, x.m, x.v, x.e);
        else passed++;
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      bus4 = LANES4;
      if (i == 0) begin
        apply(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        push("flush_preload", 1'b0, 32'h33, 1'b1, 1'b0);
      end else begin
        apply(1'b0, 1'b1, 1'b1, 1'b1, 2'd1);
        push("flush_over_stall", 1'b0, 32'h0, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
      begin
        exp_t x = sb.pop_front();
        checks++;
        if (m4 !== x.m || v4 !== x.v || e4 !== x.e)
          $display("FAIL %s: got m_out=%h valid=%b err=%b want %h %b %b",
                   x.name, m4, v4, e4, x.m, x.v, x.e);
        else passed++;
      end
    end
  endtask

  task automatic test_sel_err();
    bus3 = LANES3;
    for (int i = 0; i < 5; i++) begin
      unique case (i)
        0: begin
          apply(1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
          push("err_default", 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        end
        1: begin
          apply(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
          push("err_sticky", 1'b1, 32'h111, 1'b1, 1'b1);
        end
        2: begin
          apply(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
          push("err_kept_by_flush", 1'b1, 32'h0, 1'b0, 1'b1);
        end
        3: begin
          apply(1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
          push("err_reset_midstream", 1'b1, 32'h0, 1'b0, 1'b0);
        end
        default: begin
          apply(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
          push("first_load_after_reset", 1'b1, 32'h333, 1'b1, 1'b0);
        end
      endcase
      @(posedge clk); #1;
      begin
        exp_t x = sb.pop_front();
        checks++;
        if (m3 !== x.m || v3 !== x.v || e3 !== x.e)
          $display("FAIL %s: got m_out=%h valid=%b err=%b want %h %b %b",
                   x.name, m3, v3, e3, x.m, x.v, x.e);
        else passed++;
      end
    end
  endtask

  task automatic test_invalid();
    bus4 = LANES4; bus3 = LANES3;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        apply(1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
        push("inv_load_n4", 1'b0, 32'h22, 1'b1, 1'b0);
        push("inv_load_n3", 1'b1, 32'h222, 1'b1, 1'b0);
      end else if (i == 1) begin
        apply(1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        push("inv_hold_n4", 1'b0, 32'h22, 1'b0, 1'b0);
        push("inv_oor_n3", 1'b1, 32'h222, 1'b0, 1'b0);
      end else if (i == 2) begin
        apply(1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
        push("b2b_n4_sel3", 1'b0, 32'h44, 1'b1, 1'b0);
        push("b2b_n3_sel3", 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
      end else begin
        apply(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        push("b2b_n4_sel0", 1'b0, 32'h11, 1'b1, 1'b0);
        push("b2b_n3_sel0", 1'b1, 32'h111, 1'b1, 1'b1);
      end
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        exp_t x = sb.pop_front();
        logic [31:0] am = x.d3 ? m3 : m4;
        logic av = x.d3 ? v3 : v4;
        logic ae = x.d3 ? e3 : e4;
        checks++;
        if (am !== x.m || av !== x.v || ae !== x.e)
          $display("FAIL %s: got m_out=%h valid=%b err=%b want %h %b %b",
                   x.name, am, av, ae, x.m, x.v, x.e);
        else passed++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want earlier");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sweep();
    test_stall();
    test_flush();
    test_sel_err();
    test_invalid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
